// File: rtl/simple_axi_burst_master.sv
// Single-outstanding AXI4 burst master: one host command becomes one INCR burst
// with lane steering, byte strobes, command validation and sticky status flags.
module simple_axi_burst_master #(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_MAX_BURST  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [1:0]                i_rw,
  input  logic [2:0]                i_size,
  input  logic [31:0]               i_addr,
  input  logic [7:0]                i_len,
  input  logic [C_DATA_WIDTH-1:0]   i_wdata,
  input  logic                      i_wvalid,
  output logic                      o_wready,
  output logic [C_DATA_WIDTH-1:0]   o_rdata,
  output logic                      o_rvalid,
  input  logic                      i_rready,
  output logic                      o_wait,
  input  logic                      i_clear,
  output logic                      o_done,
  output logic                      o_error,
  output logic                      o_invalid,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [31:0]               m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic [3:0]                m_axi_awcache,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                      m_axi_wlast,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  input  logic [1:0]                m_axi_bresp,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  output logic [31:0]               m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic [3:0]                m_axi_arcache,
  output logic [2:0]                m_axi_arprot,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  input  logic [C_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast
);

  localparam int NB = C_DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam logic [2:0] MAX_SIZE = 3'(OW);

  typedef enum logic [2:0] {
    S_IDLE, S_AADDR, S_WDATA, S_WRESP, S_RDATA, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  beat_q, beat_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        invalid_q, invalid_d;

  logic [8:0]              cmd_beats;
  logic [16:0]             cmd_span;
  logic [16:0]             cmd_end;
  logic                    cmd_invalid;
  logic [OW-1:0]           off;
  logic                    last_beat;
  logic [31:0]             beat_inc;
  logic [NB-1:0]           strb_base;
  logic [C_DATA_WIDTH-1:0] data_mask;
  logic                    unused_bits;

  assign unused_bits = ^{m_axi_bresp[0], m_axi_rresp[0]};

  // Command validation looks at the raw inputs so a bad command never reaches AXI.
  always_comb begin
    cmd_beats   = {1'b0, i_len} + 9'd1;
    cmd_span    = {8'd0, cmd_beats} << i_size;
    cmd_end     = {5'd0, i_addr[11:0]} + cmd_span;
    cmd_invalid = (i_rw == 2'b11)
               || (i_size > MAX_SIZE)
               || ((i_addr & ((32'd1 << i_size) - 32'd1)) != 32'd0)
               || ({1'b0, i_len} >= 9'(C_MAX_BURST))
               || (cmd_end > 17'd4096);
  end

  always_comb begin
    off       = addr_q[OW-1:0];
    last_beat = (beat_q == len_q);
    beat_inc  = 32'd1 << size_q;
    strb_base = '0;
    for (int i = 0; i < NB; i++) strb_base[i] = (i < (1 << size_q));
    data_mask = '0;
    for (int i = 0; i < C_DATA_WIDTH; i++) data_mask[i] = strb_base[i/8];
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_IDLE;
      write_q   <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      done_q    <= done_d;
      error_q   <= error_d;
      invalid_q <= invalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    size_d    = size_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    done_d    = done_q;
    error_d   = error_q;
    invalid_d = invalid_q;

    m_axi_awvalid = 1'b0;
    m_axi_awaddr  = '0;
    m_axi_awlen   = '0;
    m_axi_awsize  = '0;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = '0;
    m_axi_arlen   = '0;
    m_axi_arsize  = '0;
    m_axi_wvalid  = 1'b0;
    m_axi_wdata   = '0;
    m_axi_wstrb   = '0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_rready  = 1'b0;
    o_wready      = 1'b0;
    o_rvalid      = 1'b0;
    o_rdata       = '0;

    case (state_q)
      S_IDLE: begin
        if (i_rw != 2'b00) begin
          write_d = i_rw[1];
          size_d  = i_size;
          addr_d  = i_addr;
          len_d   = i_len;
          beat_d  = '0;
          if (cmd_invalid) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            invalid_d = 1'b1;
          end else begin
            state_d = S_AADDR;
          end
        end
      end
      S_AADDR: begin
        if (write_q) begin
          m_axi_awvalid = 1'b1;
          m_axi_awaddr  = addr_q;
          m_axi_awlen   = len_q;
          m_axi_awsize  = size_q;
          if (m_axi_awready) state_d = S_WDATA;
        end else begin
          m_axi_arvalid = 1'b1;
          m_axi_araddr  = addr_q;
          m_axi_arlen   = len_q;
          m_axi_arsize  = size_q;
          if (m_axi_arready) state_d = S_RDATA;
        end
      end
      S_WDATA: begin
        m_axi_wvalid = i_wvalid;
        o_wready     = m_axi_wready;
        m_axi_wdata  = i_wdata << {off, 3'b000};
        m_axi_wstrb  = strb_base << off;
        m_axi_wlast  = last_beat;
        if (i_wvalid && m_axi_wready) begin
          beat_d = beat_q + 8'd1;
          addr_d = addr_q + beat_inc;
          if (last_beat) state_d = S_WRESP;
        end
      end
      S_WRESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (m_axi_bresp[1]) error_d = 1'b1;
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_RDATA: begin
        m_axi_rready = i_rready;
        o_rvalid     = m_axi_rvalid;
        o_rdata      = (m_axi_rdata >> {off, 3'b000}) & data_mask;
        // The beat counter owns completion; a wrong rlast only flags an error.
        if (m_axi_rvalid && i_rready) begin
          if (m_axi_rresp[1] || (m_axi_rlast != last_beat)) error_d = 1'b1;
          beat_d = beat_q + 8'd1;
          addr_d = addr_q + beat_inc;
          if (last_beat) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (i_clear) begin
          state_d   = S_IDLE;
          done_d    = 1'b0;
          error_d   = 1'b0;
          invalid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_wait    = (state_q == S_AADDR) || (state_q == S_WDATA)
                  || (state_q == S_WRESP) || (state_q == S_RDATA);
  assign o_done    = done_q;
  assign o_error   = error_q;
  assign o_invalid = invalid_q;

  assign m_axi_awburst = 2'b01;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;

endmodule

// File: tb/tb_simple_axi_burst_master.sv
// Bench for simple_axi_burst_master: a table of commands replayed against a
// scoreboarded host/slave model, plus hand sequences for rlast and mid-burst reset.
module tb_simple_axi_burst_master;

  localparam int DW = 64;
  localparam int NB = 8;

  logic          i_clk, i_rstn;
  logic [1:0]    i_rw;
  logic [2:0]    i_size;
  logic [31:0]   i_addr;
  logic [7:0]    i_len;
  logic [DW-1:0] i_wdata;
  logic          i_wvalid, o_wready;
  logic [DW-1:0] o_rdata;
  logic          o_rvalid, i_rready, o_wait, i_clear;
  logic          o_done, o_error, o_invalid;
  logic          m_axi_awvalid, m_axi_awready;
  logic [31:0]   m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic [3:0]    m_axi_awcache;
  logic [2:0]    m_axi_awprot;
  logic          m_axi_wvalid, m_axi_wready;
  logic [DW-1:0] m_axi_wdata;
  logic [NB-1:0] m_axi_wstrb;
  logic          m_axi_wlast;
  logic          m_axi_bvalid, m_axi_bready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_arvalid, m_axi_arready;
  logic [31:0]   m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic [3:0]    m_axi_arcache;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_rvalid, m_axi_rready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;

  simple_axi_burst_master #(.C_DATA_WIDTH(DW), .C_MAX_BURST(16)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_rw(i_rw), .i_size(i_size), .i_addr(i_addr),
    .i_len(i_len), .i_wdata(i_wdata), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_rdata(o_rdata), .o_rvalid(o_rvalid), .i_rready(i_rready), .o_wait(o_wait),
    .i_clear(i_clear), .o_done(o_done), .o_error(o_error), .o_invalid(o_invalid),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]  rw;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  len;
    int          resp_beat;
    int          rlast_beat;
    logic [63:0] rdata0;
    bit          exp_invalid;
    bit          exp_error;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } beat_t;

  beat_t sb[$];
  vec_t  vecs[11];
  int    vectors = 0;
  int    miscompares = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s timeout waiting for handshake", name);
  endtask

  function automatic logic [63:0] byteMask(input logic [2:0] size);
    logic [63:0] m;
    m = (size >= 3'd3) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 << size)) - 64'd1);
    return m;
  endfunction

  task automatic issueCmd(input logic [1:0] rw, input logic [2:0] size,
                          input logic [31:0] addr, input logic [7:0] len);
    @(negedge i_clk);
    i_rw = rw; i_size = size; i_addr = addr; i_len = len;
    @(posedge i_clk);
    #1 i_rw = 2'b00;
  endtask

  task automatic addrPhase(input bit write, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, output bit ok);
    int guard = 0;
    ok = 1'b0;
    while (!ok) begin
      @(negedge i_clk);
      if (write) m_axi_awready = ($urandom_range(0, 1) == 1);
      else       m_axi_arready = ($urandom_range(0, 1) == 1);
      #1;
      if (write && m_axi_awvalid && m_axi_awready) begin
        ok = 1'b1;
        checkOutput("awaddr", m_axi_awaddr, addr);
        checkOutput("awlen", m_axi_awlen, len);
        checkOutput("awsize", m_axi_awsize, size);
        checkOutput("o_wait_aw", o_wait, 1'b1);
      end else if (!write && m_axi_arvalid && m_axi_arready) begin
        ok = 1'b1;
        checkOutput("araddr", m_axi_araddr, addr);
        checkOutput("arlen", m_axi_arlen, len);
        checkOutput("arsize", m_axi_arsize, size);
      end
      guard++;
      if (!ok && guard > 40) begin
        timeoutFail(write ? "aw" : "ar");
        break;
      end
    end
    @(posedge i_clk);
    #1 m_axi_awready = 1'b0; m_axi_arready = 1'b0;
  endtask

  task automatic checkStatus(input string tag, input bit inv, input bit err);
    @(negedge i_clk);
    #1;
    checkOutput({tag, "_done"}, o_done, 1'b1);
    checkOutput({tag, "_error"}, o_error, err);
    checkOutput({tag, "_invalid"}, o_invalid, inv);
    checkOutput({tag, "_wait"}, o_wait, 1'b0);
    checkOutput({tag, "_valids"}, {m_axi_awvalid, m_axi_arvalid, m_axi_wvalid}, 3'b000);
  endtask

  task automatic doClear();
    @(negedge i_clk);
    i_clear = 1'b1;
    @(posedge i_clk);
    #1 i_clear = 1'b0;
    @(negedge i_clk);
    checkOutput("clear_flags", {o_done, o_error, o_invalid}, 3'b000);
  endtask

  // Write burst; abort_beat >= 0 asserts reset while that beat is on the bus.
  task automatic runWrite(input vec_t v, input int abort_beat);
    bit ok;
    beat_t b, got;
    logic [31:0] a;
    logic [63:0] hd;
    logic [15:0] m;
    int guard;
    issueCmd(v.rw, v.size, v.addr, v.len);
    addrPhase(1'b1, v.addr, v.len, v.size, ok);
    if (!ok) return;
    for (int k = 0; k <= int'(v.len); k++) begin
      a  = v.addr + (32'(k) << v.size);
      hd = {$urandom, $urandom} & byteMask(v.size);
      m  = (16'd1 << (16'd1 << v.size)) - 16'd1;
      b.data = hd << (8 * a[2:0]);
      b.strb = 8'(m << a[2:0]);
      b.last = (k == int'(v.len));
      sb.push_back(b);
      @(negedge i_clk);
      i_wdata = hd; i_wvalid = 1'b1;
      if (k == abort_beat) begin
        i_rstn = 1'b0;
        #1;
        checkOutput("rst_axi", {m_axi_wvalid, o_wready, m_axi_awvalid, m_axi_bready}, 4'b0000);
        checkOutput("rst_wdata", {m_axi_wdata, m_axi_wstrb, m_axi_wlast}, 73'd0);
        checkOutput("rst_flags", {o_wait, o_done, o_error, o_invalid}, 4'b0000);
        i_wvalid = 1'b0;
        sb.delete();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rstn = 1'b1;
        return;
      end
      guard = 0;
      ok = 1'b0;
      while (!ok) begin
        m_axi_wready = ($urandom_range(0, 2) != 0);
        #1;
        if (m_axi_wvalid && m_axi_wready) begin
          ok = 1'b1;
          got = sb.pop_front();
          checkOutput("o_wready", o_wready, 1'b1);
          checkOutput("wdata", m_axi_wdata, got.data);
          checkOutput("wstrb", m_axi_wstrb, got.strb);
          checkOutput("wlast", m_axi_wlast, got.last);
        end else begin
          guard++;
          if (guard > 40) begin
            timeoutFail("w");
            return;
          end
          @(negedge i_clk);
        end
      end
      @(posedge i_clk);
      #1 i_wvalid = 1'b0; m_axi_wready = 1'b0;
    end
    @(negedge i_clk);
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = (v.resp_beat >= 0) ? 2'b10 : 2'b00;
    #1;
    checkOutput("bready", m_axi_bready, 1'b1);
    checkOutput("done_before_b", o_done, 1'b0);
    @(posedge i_clk);
    #1 m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    checkStatus("wr", 1'b0, v.exp_error);
    doClear();
  endtask

  task automatic runRead(input vec_t v);
    bit ok, held;
    beat_t b, got;
    logic [31:0] a;
    logic [63:0] rd;
    int k, guard;
    int lastb;
    issueCmd(v.rw, v.size, v.addr, v.len);
    addrPhase(1'b0, v.addr, v.len, v.size, ok);
    if (!ok) return;
    lastb = (v.rlast_beat >= 0) ? v.rlast_beat : int'(v.len);
    k = 0; guard = 0; held = 1'b0; rd = '0;
    while (k <= int'(v.len)) begin
      @(negedge i_clk);
      if (!held) begin
        a  = v.addr + (32'(k) << v.size);
        rd = (k == 0 && v.rdata0 != 64'd0) ? v.rdata0 : {$urandom, $urandom};
        b.data = (rd >> (8 * a[2:0])) & byteMask(v.size);
        b.strb = '0;
        b.last = (k == int'(v.len));
        sb.push_back(b);
        held = 1'b1;
      end
      m_axi_rdata  = rd;
      m_axi_rvalid = m_axi_rvalid || ($urandom_range(0, 1) == 1);
      m_axi_rlast  = (k == lastb);
      m_axi_rresp  = (k == v.resp_beat) ? 2'b10 : 2'b00;
      i_rready     = ($urandom_range(0, 2) != 0);
      #1;
      if (m_axi_rvalid && i_rready) begin
        got = sb.pop_front();
        checkOutput("rready", m_axi_rready, 1'b1);
        checkOutput("o_rvalid", o_rvalid, 1'b1);
        checkOutput("o_rdata", o_rdata, got.data);
        k++;
        held = 1'b0;
        @(posedge i_clk);
        #1 m_axi_rvalid = 1'b0;
      end else begin
        guard++;
        if (guard > 80) begin
          timeoutFail("r");
          return;
        end
      end
    end
    i_rready = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
    checkStatus("rd", 1'b0, v.exp_error);
    doClear();
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.exp_invalid) begin
      issueCmd(v.rw, v.size, v.addr, v.len);
      checkStatus("inv", 1'b1, 1'b0);
      doClear();
    end else if (v.rw == 2'b10) begin
      runWrite(v, -1);
    end else begin
      runRead(v);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t hv;
    //        rw     size  addr          len    resp rlast rdata0                  inv  err
    vecs[0]  = '{2'b10, 3'd3, 32'h0000_1000, 8'd3,  -1, -1, 64'd0,                  1'b0, 1'b0};
    vecs[1]  = '{2'b10, 3'd2, 32'h0000_1004, 8'd1,  -1, -1, 64'd0,                  1'b0, 1'b0};
    vecs[2]  = '{2'b01, 3'd1, 32'h0000_2002, 8'd0,   0, -1, 64'h1234_5678_BEEF_0000, 1'b0, 1'b1};
    vecs[3]  = '{2'b10, 3'd3, 32'h0000_0FF8, 8'd1,  -1, -1, 64'd0,                  1'b1, 1'b0};
    vecs[4]  = '{2'b01, 3'd1, 32'h0000_0003, 8'd0,  -1, -1, 64'd0,                  1'b1, 1'b0};
    vecs[5]  = '{2'b11, 3'd0, 32'h0000_0000, 8'd0,  -1, -1, 64'd0,                  1'b1, 1'b0};
    vecs[6]  = '{2'b10, 3'd0, 32'h0000_0100, 8'd16, -1, -1, 64'd0,                  1'b1, 1'b0};
    vecs[7]  = '{2'b01, 3'd4, 32'h0000_0000, 8'd0,  -1, -1, 64'd0,                  1'b1, 1'b0};
    vecs[8]  = '{2'b10, 3'd0, 32'h0000_0F00, 8'd15,  0, -1, 64'd0,                  1'b0, 1'b1};
    vecs[9]  = '{2'b01, 3'd3, 32'h0000_0FC0, 8'd7,  -1, -1, 64'd0,                  1'b0, 1'b0};
    vecs[10] = '{2'b10, 3'd3, 32'h0000_0FF8, 8'd0,  -1, -1, 64'd0,                  1'b0, 1'b0};

    i_rstn = 1'b0; i_rw = '0; i_size = '0; i_addr = '0; i_len = '0;
    i_wdata = '0; i_wvalid = 1'b0; i_rready = 1'b0; i_clear = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = '0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("rst_status", {o_wait, o_done, o_error, o_invalid, o_rvalid, o_wready}, 6'd0);
    checkOutput("rst_valids", {m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_bready, m_axi_rready}, 5'd0);
    checkOutput("rst_consts", {m_axi_awburst, m_axi_awcache, m_axi_awprot,
                               m_axi_arburst, m_axi_arcache, m_axi_arprot}, 18'b01_0011_000_01_0011_000);
    i_rstn = 1'b1;

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

    $display("[TB] read len 3 with early rlast and stalls");
    hv = '{2'b01, 3'd3, 32'h0000_3000, 8'd3, -1, 2, 64'd0, 1'b0, 1'b1};
    runRead(hv);

    $display("[TB] reset during write beat 2, then a fresh write");
    runWrite(vecs[0], 2);
    @(negedge i_clk);
    checkOutput("post_rst", {o_wait, o_done, o_error, o_invalid}, 4'b0000);
    applyStimulus(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
